// File: rtl/muldiv_pkg.sv
// Shared definitions for the muldiv unit: state encoding, word width, iteration count.
// Also holds the two's-complement magnitude helper used when a divide starts.
package muldiv_pkg;
    localparam int WORD_W     = 32;
    localparam int ITERATIONS = 32;

    typedef enum logic [2:0] {IDLE, MULT, DIV, FIX, DONE} state_t;

    function automatic logic [WORD_W-1:0] mag(input logic [WORD_W-1:0] v);
        return v[WORD_W-1] ? -v : v;
    endfunction
endpackage

// File: rtl/div_step.sv
// One restoring-division iteration on unsigned magnitudes; purely combinational.
// The remainder is assumed below the divisor, so the borrow bit alone decides the quotient bit.
module div_step
    import muldiv_pkg::*;
(
    input  logic [WORD_W-1:0] rem,
    input  logic [WORD_W-1:0] quo,
    input  logic [WORD_W-1:0] dvs,
    output logic [WORD_W-1:0] rem_next,
    output logic [WORD_W-1:0] quo_next
);
    logic [WORD_W:0] rem_sh;
    logic [WORD_W:0] diff;
    logic            fits;

    always_comb begin
        rem_sh   = {rem, quo[WORD_W-1]};
        diff     = rem_sh - {1'b0, dvs};
        fits     = ~diff[WORD_W];
        rem_next = fits ? diff[WORD_W-1:0] : rem_sh[WORD_W-1:0];
        quo_next = {quo[WORD_W-2:0], fits};
    end
endmodule

// File: rtl/muldiv_unit.sv
// Signed 32x32 multiply (radix-2 Booth, or single cycle with MULDIV_FAST_MULT_EN) and signed divide.
// Result after 33 cycles (multiply) / 34 (divide); start requests are ignored while busy.
module muldiv_unit
    import muldiv_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        MULT_on,
    input  logic        DIV_on,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] Hi,
    output logic [31:0] Lo,
    output logic        busy,
    output logic        done,
    output logic        div_zero
);
    state_t            state, state_next;
    logic [5:0]        cnt;
    logic [WORD_W:0]   acc;     // product high part (one guard bit) or running remainder
    logic [WORD_W-1:0] low;     // multiplier / product low part, or running quotient
    logic [WORD_W-1:0] m;       // multiplicand, or divisor magnitude
    logic              q_m1;
    logic              neg_q, neg_r, b_zero;
    logic              last;
    logic [WORD_W-1:0] rem_d, quo_d;

    assign last = (cnt == 6'(ITERATIONS - 1));

`ifdef MULDIV_FAST_MULT_EN
    logic signed [2*WORD_W-1:0] prod;
    assign prod = $signed(low) * $signed(m);
`else
    logic [WORD_W:0]   booth_sum, acc_b;
    logic [WORD_W-1:0] low_b;

    always_comb begin
        case ({low[0], q_m1})
            2'b01:   booth_sum = acc + {m[WORD_W-1], m};
            2'b10:   booth_sum = acc - {m[WORD_W-1], m};
            default: booth_sum = acc;
        endcase
        acc_b = {booth_sum[WORD_W], booth_sum[WORD_W:1]};
        low_b = {booth_sum[0], low[WORD_W-1:1]};
    end
`endif

    div_step u_div_step (
        .rem      (acc[WORD_W-1:0]),
        .quo      (low),
        .dvs      (m),
        .rem_next (rem_d),
        .quo_next (quo_d)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        busy       = (state != IDLE);
        done       = (state == DONE);
        div_zero   = (state == DIV) && b_zero;
        case (state)
            IDLE: begin
                if (MULT_on)     state_next = MULT;
                else if (DIV_on) state_next = DIV;
            end
`ifdef MULDIV_FAST_MULT_EN
            MULT: state_next = DONE;
`else
            MULT: if (last) state_next = DONE;
`endif
            DIV: begin
                if (b_zero)    state_next = IDLE;
                else if (last) state_next = FIX;
            end
            FIX:     state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt    <= '0;
            acc    <= '0;
            low    <= '0;
            m      <= '0;
            q_m1   <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            b_zero <= 1'b0;
            Hi     <= '0;
            Lo     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (MULT_on) begin
                        acc    <= '0;
                        low    <= A;
                        m      <= B;
                        q_m1   <= 1'b0;
                        b_zero <= 1'b0;
                    end else if (DIV_on) begin
                        acc    <= '0;
                        low    <= mag(A);
                        m      <= mag(B);
                        neg_q  <= A[WORD_W-1] ^ B[WORD_W-1];
                        neg_r  <= A[WORD_W-1];
                        b_zero <= (B == '0);
                    end
                end
                MULT: begin
`ifdef MULDIV_FAST_MULT_EN
                    Hi <= prod[2*WORD_W-1:WORD_W];
                    Lo <= prod[WORD_W-1:0];
`else
                    acc  <= acc_b;
                    low  <= low_b;
                    q_m1 <= low[0];
                    cnt  <= cnt + 6'd1;
                    if (last) begin
                        Hi <= acc_b[WORD_W-1:0];
                        Lo <= low_b;
                    end
`endif
                end
                DIV: begin
                    acc <= {1'b0, rem_d};
                    low <= quo_d;
                    cnt <= cnt + 6'd1;
                end
                FIX: begin
                    Hi <= neg_r ? -acc[WORD_W-1:0] : acc[WORD_W-1:0];
                    Lo <= neg_q ? -low : low;
                end
                default: ;
            endcase
        end
    end
endmodule
